// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_ctrl_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Host-side handshake and operand/result bus for serial_sub_ctrl.
interface serial_sub_ctrl_if #(parameter int WIDTH = serial_sub_ctrl_pkg::DEF_WIDTH);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (output start, a, b, bin, input busy, done, diff, bout);
   modport slave  (input start, a, b, bin, output busy, done, diff, bout);

endinterface

// File: rtl/serial_sub_ctrl_fs_cell.sv
// Combinational 1-bit full subtractor: d = m - n - bin, bout = borrow out.
module fs_cell (
   input  logic m,
   input  logic n,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = m ^ n ^ bin;
   assign bout = (n & bin) | (~m & bin) | (~m & n);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B - BIN, LSB first; WIDTH cycles busy, then a one-cycle done.
// start is only accepted in IDLE or DONE; requests while busy are dropped.
module serial_sub_ctrl
   import serial_sub_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   serial_sub_ctrl_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] d_sh;
   logic [WIDTH-1:0] d_next;
   logic [WIDTH-1:0] diff_q;
   logic             brw;
   logic             bout_q;
   logic             cell_d;
   logic             cell_bo;
   logic             accept;
   logic             last;
   logic             busy_c;
   logic             done_c;

   fs_cell u_cell (
      .m    (a_sh[0]),
      .n    (b_sh[0]),
      .bin  (brw),
      .d    (cell_d),
      .bout (cell_bo)
   );

   assign d_next = {cell_d, d_sh[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SHIFT;
         SHIFT:   if (last)      state_nxt = DONE;
         DONE:    state_nxt = bus.start ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // busy/done decode straight from the state flops, so they stay registered.
   always_comb begin
      accept = 1'b0;
      last   = 1'b0;
      busy_c = 1'b0;
      done_c = 1'b0;
      case (state)
         IDLE:  accept = bus.start;
         SHIFT: begin
            busy_c = 1'b1;
            last   = (cnt == CW'(WIDTH - 1));
         end
         DONE: begin
            done_c = 1'b1;
            accept = bus.start;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         d_sh   <= '0;
         brw    <= 1'b0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else if (accept) begin
         cnt  <= '0;
         a_sh <= bus.a;
         b_sh <= bus.b;
         brw  <= bus.bin;
         d_sh <= '0;
      end else if (state == SHIFT) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         brw  <= cell_bo;
         d_sh <= d_next;
         // Counter holds on the last bit so it never reaches WIDTH.
         if (last) begin
            diff_q <= d_next;
            bout_q <= cell_bo;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign bus.busy = busy_c;
   assign bus.done = done_c;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl plus an exhaustive fs_cell check.
module tb_serial_sub_ctrl;
   import serial_sub_ctrl_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [W:0] exp_q[$];
   logic [W:0] prev_exp = '0;

   serial_sub_ctrl_if #(.WIDTH(W)) bus ();

   serial_sub_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic cm, cn, cb, cd, cbo;
   fs_cell u_cell_chk (.m(cm), .n(cn), .bin(cb), .d(cd), .bout(cbo));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      logic [W:0] t;
      t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      return t;
   endfunction

   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            check("diff", 32'(bus.diff), 32'(e[W-1:0]));
            check("bout", 32'(bus.bout), 32'(e[W]));
         end
      end
   end

   // One operation from a negedge; returns negedges to done and busy cycles seen.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit disturb, output int lat, output int busy_n);
      logic [W:0] e;
      e = model(a, b, bin);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      exp_q.push_back(e);
      busy_n = 0;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 40) begin
         if (bus.busy) busy_n++;
         if (lat == 2) begin
            check("hold_diff", 32'(bus.diff), 32'(prev_exp[W-1:0]));
            check("hold_bout", 32'(bus.bout), 32'(prev_exp[W]));
         end
         if (disturb && lat == 3) begin
            bus.start = 1'b1;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.bin   = 1'($urandom);
         end
         if (disturb && lat == 5) bus.start = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (lat >= 40) check("done_timeout", 32'd0, 32'd1);
      prev_exp = e;
   endtask

   int lat, bn, t;
   logic [1:0] ref2;

   initial begin
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_diff", 32'(bus.diff), 32'd0);
      check("rst_bout", 32'(bus.bout), 32'd0);
      rst = 1'b0;

      do_op(8'h5A, 8'h3C, 1'b0, 1'b0, lat, bn);
      check("lat_5a", 32'(lat), 32'd9);
      check("busy_5a", 32'(bn), 32'd8);
      check("e_5a", 32'(prev_exp), 32'h01E);
      @(negedge clk);
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("diff_held_idle", 32'(bus.diff), 32'h1E);

      do_op(8'h00, 8'h01, 1'b0, 1'b0, lat, bn);
      check("lat_00", 32'(lat), 32'd9);
      do_op(8'h10, 8'h10, 1'b1, 1'b0, lat, bn);
      check("lat_10", 32'(lat), 32'd9);

      do_op(8'hFF, 8'h00, 1'b0, 1'b1, lat, bn);
      check("lat_disturb", 32'(lat), 32'd9);
      check("busy_disturb", 32'(bn), 32'd8);
      repeat (12) @(negedge clk);
      check("idle_after_disturb", 32'(bus.busy), 32'd0);

      // Back-to-back: start held through the done cycle.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'h80;
      bus.b     = 8'h01;
      bus.bin   = 1'b0;
      exp_q.push_back(model(8'h80, 8'h01, 1'b0));
      t = 0;
      while (!bus.done && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("b2b_first_lat", 32'(t), 32'd9);
      exp_q.push_back(model(8'h80, 8'h01, 1'b0));
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_no_bubble", 32'(bus.busy), 32'd1);
      t = 1;
      while (!bus.done && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("b2b_gap", 32'(t), 32'd9);
      prev_exp = model(8'h80, 8'h01, 1'b0);
      @(negedge clk);

      // Asynchronous reset during the 4th SHIFT cycle; this result is discarded.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'h12;
      bus.b     = 8'h34;
      bus.bin   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      check("arst_diff", 32'(bus.diff), 32'd0);
      check("arst_bout", 32'(bus.bout), 32'd0);
      #1 rst = 1'b0;
      prev_exp = '0;
      repeat (12) @(negedge clk);
      check("post_rst_idle", 32'(bus.busy), 32'd0);

      do_op(8'h33, 8'h44, 1'b1, 1'b0, lat, bn);
      check("lat_post_rst", 32'(lat), 32'd9);
      repeat (2) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      for (int i = 0; i < 8; i++) begin
         {cm, cn, cb} = i[2:0];
         #1;
         ref2 = {1'b0, cm} - {1'b0, cn} - {1'b0, cb};
         check("cell_d", 32'(cd), 32'(ref2[0]));
         check("cell_bout", 32'(cbo), 32'(ref2[1]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial subtraction controller that computes A - B - BIN on WIDTH-bit operands using a single 1-bit full-subtractor cell.
- Feeds the cell LSB-first, one bit per clock.
- Keeps the running borrow in a flip-flop between bits.
- Assembles the difference in a shift register.
- Uses a start/busy/done handshake so a host FSM or testbench can issue operations back to back.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      asynchronous, active-high reset
- start  input   1      request a new operation; sampled only when idle or done
- a      input   WIDTH  minuend, captured on an accepted start
- b      input   WIDTH  subtrahend, captured on an accepted start
- bin    input   1      borrow-in, captured on an accepted start
- busy   output  1      high while bits are being processed
- done   output  1      one-cycle pulse: result valid
- diff   output  WIDTH  difference, (a - b - bin) mod 2^WIDTH
- bout   output  1      final borrow-out (1 when a < b + bin, unsigned)

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, diff=0, bout=0, bit counter=0, operand/borrow/difference shift registers=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at a rising edge → capture a, b, bin into a_sh, b_sh, brw; clear counter and d_sh; go to SHIFT.
  - busy=1 from the following cycle.
- SHIFT, every cycle:
  - Cell inputs: m=a_sh[0], n=b_sh[0], bin=brw.
  - Cell equations: d = m^n^bin; bo = (n&bin)|(~m&bin)|(~m&n).
  - d_sh <= {d, d_sh[WIDTH-1:1]}; a_sh and b_sh shift right by one; brw <= bo; counter++.
  - When counter == WIDTH-1 in SHIFT:
    - diff <= final assembled {d, d_sh[WIDTH-1:1]};
    - bout <= bo;
    - done <= 1; busy <= 0; next state DONE.
- DONE:
  - done is high for exactly this one cycle.
  - diff/bout hold until the next accepted start completes.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back, no bubble); otherwise → IDLE.
- Latency: start sampled at edge 0 → busy high for edges 1..WIDTH → done high in the cycle after edge WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start while busy (SHIFT) is ignored; captured operands are unaffected and inputs a/b/bin may change freely.
- diff/bout are not updated during SHIFT; they show the previous result, or 0 after reset.
- Reset asserted mid-operation: immediate return to reset values; partial result discarded; no done pulse.
- Counter width is $clog2(WIDTH); it wraps/clears only via start or reset and never reaches WIDTH.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - default WIDTH constant.
- Sub-module fs_cell (m, n, bin → d, bout): purely combinational 1-bit full subtractor, instantiated once. It lets the cell be verified exhaustively on its own.
- The controller holds the FSM, counter, shift registers and borrow flop.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start one cycle → busy high 8 cycles; done pulse on cycle 9; diff=0x1E, bout=0.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Then a=0x10, b=0x10, bin=1 → diff=0xFF, bout=1.
- a=0xFF, b=0x00, bin=0 → diff=0xFF, bout=0. During SHIFT, toggle a/b/bin and pulse start → result unchanged, no extra done, busy stays 8 cycles.
- Back-to-back: start held high through the done cycle with a=0x80, b=0x01 → second op begins without an idle cycle; second done exactly 9 cycles after the first; diff=0x7F, bout=0.
- Reset pulse (asynchronous, between clock edges) at the 4th SHIFT cycle → busy/done/diff/bout drop to 0 immediately; no done pulse afterwards; a new start then completes normally.
- fs_cell exhaustive: all 8 {m,n,bin} combinations → d, bout match the full-subtractor truth table (e.g. 011→d=0,bout=1; 100→d=1,bout=0).
